// File: rtl/seg_pattern_decoder.sv
// Seven-segment readback decoder: samples two segment buses, waits for them
// to settle, decodes each to a hex nibble and reports every new stable pair
// on a valid/ready handshake with per-digit bad-glyph flags.

// Per-digit glyph decoder: 7-segment pattern (G..A) to hex nibble.
module seg_glyph_dec (
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       bad
);
  // Table lookup; anything that is not one of the 16 glyphs is flagged bad.
  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (seg)
      7'h3f: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5b: nib = 4'h2;
      7'h4f: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6d: nib = 4'h5;
      7'h7d: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7f: nib = 4'h8;
      7'h6f: nib = 4'h9;
      7'h77: nib = 4'ha;
      7'h7c: nib = 4'hb;
      7'h39: nib = 4'hc;
      7'h5e: nib = 4'hd;
      7'h79: nib = 4'he;
      7'h71: nib = 4'hf;
      default: bad = 1'b1;
    endcase
  end
endmodule

module seg_pattern_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] seg_in_1,
  input  logic [8:0] seg_in_2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] data_1,
  output logic [3:0] data_2,
  output logic       bad_1,
  output logic       bad_2,
  output logic [7:0] err_count
);
  localparam int         NUM_LANES = 2;
  localparam int         SEG_W     = 9;
  localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);

  typedef enum logic {WAIT, PRESENT} state_t;

  // Lane 0 is digit 1, lane 1 is digit 2.
  logic [NUM_LANES-1:0][SEG_W-1:0] s_q, s_d;
  logic [NUM_LANES-1:0][SEG_W-1:0] s_prev_q, s_prev_d;
  logic [NUM_LANES-1:0][SEG_W-1:0] last_pair_q, last_pair_d;
  logic                            last_vld_q, last_vld_d;
  logic [3:0]                      cnt_q, cnt_d;
  state_t                          state_q, state_d;
  logic [NUM_LANES-1:0][3:0]       data_q, data_d;
  logic [NUM_LANES-1:0]            bad_q, bad_d;
  logic [7:0]                      err_q, err_d;

  logic [NUM_LANES-1:0][3:0]       dec_nib;
  logic [NUM_LANES-1:0]            dec_bad;
  logic                            accept;

  // Decode straight off the sampled register; SEG/DP bits are not part of a glyph.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    seg_glyph_dec u_dec (
      .seg (s_q[i][6:0]),
      .nib (dec_nib[i]),
      .bad (dec_bad[i])
    );
  end

  // Accept a pattern once it has settled and differs from the last one reported.
  assign accept = (state_q == WAIT) && (cnt_q == STABLE) &&
                  (!last_vld_q || (s_q != last_pair_q));

  // Sampling, stability counter, handshake FSM and held output registers.
  always_comb begin
    s_d         = {seg_in_2, seg_in_1};
    s_prev_d    = s_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    last_pair_d = last_pair_q;
    last_vld_d  = last_vld_q;
    data_d      = data_q;
    bad_d       = bad_q;
    err_d       = err_q;

    if (s_q != s_prev_q)  cnt_d = 4'd0;
    else if (cnt_q < STABLE) cnt_d = cnt_q + 4'd1;

    case (state_q)
      WAIT: begin
        if (accept) begin
          state_d     = PRESENT;
          data_d      = dec_nib;
          bad_d       = dec_bad;
          last_pair_d = s_q;
          last_vld_d  = 1'b1;
          if ((|dec_bad) && (err_q != 8'hff)) err_d = err_q + 8'd1;
        end
      end
      PRESENT: begin
        // Outputs stay frozen until the consumer takes them.
        if (out_ready) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  // State registers; synchronous reset clears everything including a pending handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      s_prev_q    <= '0;
      cnt_q       <= '0;
      state_q     <= WAIT;
      last_pair_q <= '0;
      last_vld_q  <= 1'b0;
      data_q      <= '0;
      bad_q       <= '0;
      err_q       <= '0;
    end else begin
      s_q         <= s_d;
      s_prev_q    <= s_prev_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      last_pair_q <= last_pair_d;
      last_vld_q  <= last_vld_d;
      data_q      <= data_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = (state_q == PRESENT);
  assign data_1    = data_q[0];
  assign data_2    = data_q[1];
  assign bad_1     = bad_q[0];
  assign bad_2     = bad_q[1];
  assign err_count = err_q;
endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder with hand-computed expectations.
module tb_seg_pattern_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] seg_in_1, seg_in_2;
  logic       out_valid, out_ready;
  logic [3:0] data_1, data_2;
  logic       bad_1, bad_2;
  logic [7:0] err_count;

  int n_vec = 0;
  int n_bad = 0;

  logic [6:0] glyph [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                             7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

  seg_pattern_decoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in_1  (seg_in_1),
    .seg_in_2  (seg_in_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_1    (data_1),
    .data_2    (data_2),
    .bad_1     (bad_1),
    .bad_2     (bad_2),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Count rising edges until out_valid is seen (sampled on the falling edge).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!out_valid && n < 60);
    chk("valid_seen", 32'(out_valid), 1);
  endtask

  // Apply a pair with out_ready high, check the presented result and the 1-cycle pulse.
  task automatic xfer(input logic [8:0] a, input logic [8:0] b,
                      input logic [3:0] e1, input logic [3:0] e2,
                      input logic eb1, input logic eb2);
    int n;
    seg_in_1 = a; seg_in_2 = b;
    wait_valid(n);
    chk("data_1", 32'(data_1), 32'(e1));
    chk("data_2", 32'(data_2), 32'(e2));
    chk("bad_1",  32'(bad_1),  32'(eb1));
    chk("bad_2",  32'(bad_2),  32'(eb2));
    @(posedge clk); @(negedge clk);
    chk("pulse_end", 32'(out_valid), 0);
  endtask

  initial begin
    int n;
    int nv;
    logic frozen;

    // Reset with 1/3 already on the buses.
    rst = 1'b1; out_ready = 1'b1; seg_in_1 = 9'h006; seg_in_2 = 9'h04f;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data1", 32'(data_1), 0);
    chk("rst_data2", 32'(data_2), 0);
    chk("rst_bad",   32'({bad_1, bad_2}), 0);
    chk("rst_err",   32'(err_count), 0);

    // First edge after reset loads s_q (E0); valid rises at E6, the 7th edge counted.
    rst = 1'b0;
    wait_valid(n);
    chk("first_latency", n, 7);
    chk("first_data", 32'({data_1, data_2}), 32'h13);
    chk("first_bad",  32'({bad_1, bad_2}), 0);
    chk("first_err",  32'(err_count), 0);
    @(posedge clk); @(negedge clk);
    chk("first_pulse_end", 32'(out_valid), 0);

    // All 16 glyphs on both digits.
    for (int i = 0; i < 16; i++)
      xfer({2'b00, glyph[i]}, {2'b00, glyph[i]}, 4'(i), 4'(i), 1'b0, 1'b0);

    // Bad digit 1, legal b on digit 2.
    xfer(9'h000, 9'h07c, 4'h0, 4'hb, 1'b1, 1'b0);
    chk("err_one", 32'(err_count), 1);

    // 259 more bad pairs, alternating so each one is a change; count stops at 255.
    for (int i = 0; i < 259; i++)
      xfer((i % 2 == 0) ? 9'h001 : 9'h000, 9'h07c, 4'h0, 4'hb, 1'b1, 1'b0);
    chk("err_sat", 32'(err_count), 255);

    // Glitch to 8/8 for two cycles and back; only the 2/2 transfer appears.
    xfer(9'h05b, 9'h05b, 4'h2, 4'h2, 1'b0, 1'b0);
    seg_in_1 = 9'h07f; seg_in_2 = 9'h07f;
    @(posedge clk); @(posedge clk); @(negedge clk);
    seg_in_1 = 9'h05b; seg_in_2 = 9'h05b;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) nv++;
    end
    chk("glitch_silent", nv, 0);

    // Stall: outputs frozen while inputs change three times.
    out_ready = 1'b0;
    seg_in_1 = 9'h006; seg_in_2 = 9'h006;
    wait_valid(n);
    chk("stall_data", 32'({data_1, data_2}), 32'h11);
    frozen = 1'b1;
    for (int k = 0; k < 3; k++) begin
      seg_in_1 = {2'b00, glyph[3 + k]}; seg_in_2 = {2'b00, glyph[3 + k]};
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); @(negedge clk);
        if (!out_valid || data_1 != 4'h1 || data_2 != 4'h1 || bad_1 || bad_2) frozen = 1'b0;
      end
    end
    chk("stall_frozen", 32'(frozen), 1);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("stall_gap", 32'(out_valid), 0);
    @(posedge clk); @(negedge clk);
    chk("stall_next_valid", 32'(out_valid), 1);
    chk("stall_next_data", 32'({data_1, data_2}), 32'h55);
    @(posedge clk); @(negedge clk);
    chk("stall_next_end", 32'(out_valid), 0);

    // Reset in the middle of a held presentation.
    out_ready = 1'b0;
    seg_in_1 = 9'h07d; seg_in_2 = 9'h07d;
    wait_valid(n);
    chk("pre_rst_data", 32'({data_1, data_2}), 32'h66);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data",  32'({data_1, data_2}), 0);
    chk("mid_rst_bad",   32'({bad_1, bad_2}), 0);
    chk("mid_rst_err",   32'(err_count), 0);
    rst = 1'b0;
    wait_valid(n);
    chk("re_latency", n, 7);
    chk("re_data", 32'({data_1, data_2}), 32'h66);
    chk("re_err",  32'(err_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
